// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcodes, R-type functs, ALU control codes and
// next-PC source selects used by the decode stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [1:0] PCS_PC4 = 2'd0;
  localparam logic [1:0] PCS_BPC = 2'd1;
  localparam logic [1:0] PCS_JR  = 2'd2;
  localparam logic [1:0] PCS_JPC = 2'd3;

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports with write-through,
// one write port, r0 hardwired to zero, asynchronous clear.
module regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wn,
  input  logic [31:0] wd
);

  logic [31:0] regs [32];
  logic        wr_en;

  assign wr_en = we && (wn != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wr_en) begin
      regs[wn] <= wd;
    end
  end

  // Write-through lets WB and ID share a cycle without a separate bypass.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : (wr_en && wn == ra1) ? wd : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : (wr_en && wn == ra2) ? wd : regs[ra2];

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: decode, register read, forwarding, load-use stall,
// branch/jump resolution and the ID/EXE pipeline register.
module id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RST_PC4 = 32'h0000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc4,
  input  logic [31:0] inst,
  input  logic [4:0]  ex_rn,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [31:0] ex_alu,
  input  logic [4:0]  mem_rn,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_mo,
  input  logic [4:0]  wb_rn,
  input  logic        wb_wreg,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic [1:0]  pcsource,
  output logic [31:0] bpc,
  output logic [31:0] jpc,
  output logic [31:0] e_pc4,
  output logic [31:0] e_a,
  output logic [31:0] e_b,
  output logic [31:0] e_imm,
  output logic [4:0]  e_rn,
  output logic [3:0]  e_aluc,
  output logic        e_aluimm,
  output logic        e_shift,
  output logic        e_jal,
  output logic        e_wreg,
  output logic        e_m2reg,
  output logic        e_wmem
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign sa    = inst[10:6];
  assign funct = inst[5:0];
  assign imm16 = inst[15:0];

  logic       d_wreg, d_m2reg, d_wmem, d_jal, d_aluimm, d_shift, d_sext, d_regrt;
  logic       uses_rs, uses_rt, is_beq, is_bne, is_jr, is_j;
  logic [3:0] d_aluc;

  always_comb begin
    d_wreg = 1'b0; d_m2reg = 1'b0; d_wmem = 1'b0; d_jal = 1'b0;
    d_aluimm = 1'b0; d_shift = 1'b0; d_sext = 1'b0; d_regrt = 1'b0;
    uses_rs = 1'b0; uses_rt = 1'b0;
    is_beq = 1'b0; is_bne = 1'b0; is_jr = 1'b0; is_j = 1'b0;
    d_aluc = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin d_wreg = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; d_aluc = ALU_ADD; end
          FN_SUB: begin d_wreg = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; d_aluc = ALU_SUB; end
          FN_AND: begin d_wreg = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; d_aluc = ALU_AND; end
          FN_OR:  begin d_wreg = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; d_aluc = ALU_OR;  end
          FN_XOR: begin d_wreg = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; d_aluc = ALU_XOR; end
          FN_SLL: begin d_wreg = 1'b1; d_shift = 1'b1; uses_rt = 1'b1; d_aluc = ALU_SLL; end
          FN_SRL: begin d_wreg = 1'b1; d_shift = 1'b1; uses_rt = 1'b1; d_aluc = ALU_SRL; end
          FN_SRA: begin d_wreg = 1'b1; d_shift = 1'b1; uses_rt = 1'b1; d_aluc = ALU_SRA; end
          FN_JR:  begin is_jr = 1'b1; uses_rs = 1'b1; end
          default: ;
        endcase
      end
      OP_ADDI: begin d_wreg = 1'b1; d_aluimm = 1'b1; d_sext = 1'b1; d_regrt = 1'b1; uses_rs = 1'b1; d_aluc = ALU_ADD; end
      OP_ANDI: begin d_wreg = 1'b1; d_aluimm = 1'b1; d_regrt = 1'b1; uses_rs = 1'b1; d_aluc = ALU_AND; end
      OP_ORI:  begin d_wreg = 1'b1; d_aluimm = 1'b1; d_regrt = 1'b1; uses_rs = 1'b1; d_aluc = ALU_OR;  end
      OP_XORI: begin d_wreg = 1'b1; d_aluimm = 1'b1; d_regrt = 1'b1; uses_rs = 1'b1; d_aluc = ALU_XOR; end
      OP_LUI:  begin d_wreg = 1'b1; d_aluimm = 1'b1; d_regrt = 1'b1; d_aluc = ALU_LUI; end
      OP_LW: begin
        d_wreg = 1'b1; d_m2reg = 1'b1; d_aluimm = 1'b1; d_sext = 1'b1;
        d_regrt = 1'b1; uses_rs = 1'b1; d_aluc = ALU_ADD;
      end
      OP_SW: begin
        d_wmem = 1'b1; d_aluimm = 1'b1; d_sext = 1'b1;
        uses_rs = 1'b1; uses_rt = 1'b1; d_aluc = ALU_ADD;
      end
      OP_BEQ: begin is_beq = 1'b1; d_sext = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_BNE: begin is_bne = 1'b1; d_sext = 1'b1; uses_rs = 1'b1; uses_rt = 1'b1; end
      OP_J:   is_j = 1'b1;
      OP_JAL: begin is_j = 1'b1; d_jal = 1'b1; d_wreg = 1'b1; end
      default: ;
    endcase
  end

  logic [31:0] qa, qb;

  regfile u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (qa),
    .rd2 (qb),
    .we  (wb_wreg),
    .wn  (wb_rn),
    .wd  (wb_data)
  );

  // A load in EX never forwards from EX; that case is covered by the stall.
  logic        ex_fwd_ok, mem_fwd_ok;
  logic [31:0] mem_val, fa, fb;

  assign ex_fwd_ok  = ex_wreg && !ex_m2reg && (ex_rn != 5'd0);
  assign mem_fwd_ok = mem_wreg && (mem_rn != 5'd0);
  assign mem_val    = mem_m2reg ? mem_mo : mem_alu;

  always_comb begin
    fa = qa;
    if (ex_fwd_ok && ex_rn == rs)        fa = ex_alu;
    else if (mem_fwd_ok && mem_rn == rs) fa = mem_val;
    fb = qb;
    if (ex_fwd_ok && ex_rn == rt)        fb = ex_alu;
    else if (mem_fwd_ok && mem_rn == rt) fb = mem_val;
  end

  assign stall = ex_wreg && ex_m2reg && (ex_rn != 5'd0) &&
                 ((uses_rs && ex_rn == rs) || (uses_rt && ex_rn == rt));

  assign bpc = pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jpc = {pc4[31:28], inst[25:0], 2'b00};

  always_comb begin
    pcsource = PCS_PC4;
    if (!stall) begin
      if ((is_beq && fa == fb) || (is_bne && fa != fb)) pcsource = PCS_BPC;
      else if (is_jr)                                   pcsource = PCS_JR;
      else if (is_j)                                    pcsource = PCS_JPC;
    end
  end

  logic [31:0] imm_val;
  logic [4:0]  rn_val;

  assign imm_val = d_shift ? {27'd0, sa} :
                   d_sext  ? {{16{imm16[15]}}, imm16} : {16'd0, imm16};
  assign rn_val  = d_jal ? 5'd31 : d_regrt ? rt : rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_pc4 <= RST_PC4;
      e_a <= 32'd0; e_b <= 32'd0; e_imm <= 32'd0;
      e_rn <= 5'd0; e_aluc <= 4'd0;
      e_aluimm <= 1'b0; e_shift <= 1'b0; e_jal <= 1'b0;
      e_wreg <= 1'b0; e_m2reg <= 1'b0; e_wmem <= 1'b0;
    end else begin
      e_pc4 <= pc4;
      e_a <= fa; e_b <= fb; e_imm <= imm_val;
      e_rn <= rn_val; e_aluc <= d_aluc;
      e_aluimm <= d_aluimm; e_shift <= d_shift;
      // A stall turns the ID/EXE slot into a bubble with no side effects.
      e_jal   <= d_jal   && !stall;
      e_wreg  <= d_wreg  && !stall;
      e_m2reg <= d_m2reg && !stall;
      e_wmem  <= d_wmem  && !stall;
    end
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage MIPS pipeline, plus the ID/EXE pipeline register.
- Decodes the IF/ID instruction and reads the register file.
- Resolves forwarding, load-use stalls, branches and jumps.
- Registers the operand and control bundle consumed by the execute stage (pc4, a, b, imm, rn, aluc, aluimm, shift, jal, plus wreg/m2reg/wmem for later stages).

Parameters:
- RST_PC4, 32'h0000_0004, reset value of e_pc4.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous active-high reset
- pc4  in  32  IF/ID PC+4
- inst  in  32  IF/ID instruction
- ex_rn  in  5  destination register of the EX instruction (for forwarding)
- ex_wreg  in  1  EX instruction writes a register
- ex_m2reg  in  1  EX instruction is a load
- ex_alu  in  32  EX result
- mem_rn  in  5  MEM-stage destination register
- mem_wreg  in  1  MEM-stage instruction writes a register
- mem_m2reg  in  1  MEM-stage instruction is a load
- mem_alu  in  32  MEM-stage ALU result
- mem_mo  in  32  MEM-stage load data
- wb_rn  in  5  WB write register
- wb_wreg  in  1  WB write enable
- wb_data  in  32  WB write data
- stall  out  1  combinational; 1 = hold PC and IF/ID
- pcsource  out  2  combinational; 0 pc4, 1 bpc, 2 rs value (jr), 3 jpc
- bpc  out  32  pc4 + (sext(imm16)<<2)
- jpc  out  32  {pc4[31:28], inst[25:0], 2'b00}
- e_pc4, e_a, e_b, e_imm  out  32 each  registered operands to EXE
- e_rn  out  5  registered destination register
- e_aluc  out  4  registered ALU control
- e_aluimm, e_shift, e_jal, e_wreg, e_m2reg, e_wmem  out  1 each  registered controls

Behaviour:
- Reset (async):
  - All 32 registers of the 32x32 register file clear to 0.
  - All e_* outputs go to 0, except e_pc4, which goes to RST_PC4.
- Register file:
  - r0 reads 0 and is never written.
  - Write at posedge when wb_wreg && wb_rn != 0.
  - Reads are combinational, with write-through: a same-cycle write to rs or rt returns wb_data.
- Supported instructions: add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lui, lw, sw, beq, bne, j, jal. Any other opcode decodes as a NOP, with all write/mem/jal controls 0.
- Immediate:
  - addi, lw, sw, beq, bne: sign-extended.
  - andi, ori, xori, lui: zero-extended.
  - Shifts: e_imm = {27'b0, sa}, and e_shift = 1.
- e_aluimm = 1 for the I-type ALU ops, lw and sw.
- Destination register:
  - R-type: rd.
  - I-type: rt.
  - jal: 31, with e_jal = 1; EXE then produces pc4+4.
- Forwarding, applied per source operand (rs, rt):
  - Priority 1, EX: ex_wreg && !ex_m2reg && ex_rn != 0 && ex_rn == src -> ex_alu.
  - Priority 2, MEM: mem_wreg && mem_rn != 0 && mem_rn == src -> mem_mo if mem_m2reg, else mem_alu.
  - Otherwise: the register-file value.
- Load-use stall:
  - stall = ex_wreg && ex_m2reg && ex_rn != 0 && ((uses_rs && ex_rn == rs) || (uses_rt && ex_rn == rt)).
  - uses_rt is true for R-type ALU ops, shifts, sw, beq and bne.
  - While stall = 1:
    - The ID/EXE register loads a bubble: e_wreg = e_wmem = e_m2reg = e_jal = 0; other fields don't-care.
    - pcsource = 0.
  - The stall lasts exactly one cycle per load-use pair.
- Branches:
  - beq/bne compare the forwarded rs and rt values in ID.
  - Branches are delayed, one slot: no flush is ever generated.
  - pcsource is combinational from the current instruction and forwarded values.
- Pipeline latency: ID -> EXE is 1 cycle.
- ALU codes: ADD 0000, SUB 0100, AND 0001, OR 0101, XOR 0010, LUI 0110, SLL 0011, SRL 0111, SRA 1111.
- Reset mid-operation: takes effect immediately. Register contents are lost, and the in-flight instruction is discarded.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct constants;
  - the ALU code constants above;
  - pcsource encodings.
- Sub-module regfile: 32x32, two read ports, one write port, async reset, write-through.
- Decode, forwarding and the ID/EXE register stay in id_stage.

Test Plan:
- Reset, then addi $1,$0,5 -> next cycle e_a = 0, e_imm = 5, e_aluimm = 1, e_rn = 1, e_wreg = 1, e_aluc = 0000.
- add $3,$1,$2 with ex_rn = 1, ex_wreg = 1, ex_alu = 7, and mem_rn = 2 with mem_m2reg = 1, mem_mo = 9 -> e_a = 7, e_b = 9.
- lw in EX (ex_rn = 4, ex_m2reg = 1) while ID holds sub $5,$4,$6 -> stall = 1 for one cycle, bubble with e_wreg = 0; next cycle stall = 0.
- beq with forwarded rs = rt = 0x10, pc4 = 0x100, imm16 = 0xFFFF -> pcsource = 1, bpc = 0x0FC; with bne instead -> pcsource = 0.
- jal target 0x40 at pc4 = 0x2000_0008 -> pcsource = 3, jpc = 0x2000_0100; next cycle e_jal = 1, e_rn = 31, e_wreg = 1.
- WB writes $7 = 0xDEAD in the same cycle ID reads $7 -> forwarded read returns 0xDEAD. A write to $0 is ignored, and $0 still reads 0.
